// File: rtl/mem_access_if.sv
// mem_access_if: EX/MEM inputs and MEM/WB-side outputs of the MEM stage.
// master drives the EX/MEM request fields; slave is the MEM stage itself.
interface mem_access_if;
  logic        ctrl_memRead_ex_mem;
  logic        ctrl_memWrite_ex_mem;
  logic [1:0]  mem_size_ex_mem;
  logic        mem_unsigned_ex_mem;
  logic [31:0] alu_result_ex_mem;
  logic [31:0] write_data_ex_mem;
  logic        ctrl_regWrite_ex_mem;
  logic        ctrl_memToReg_ex_mem;
  logic [4:0]  write_register_ex_mem;
  logic [31:0] read_data_from_mem;
  logic [31:0] alu_result_mem;
  logic        ctrl_regWrite_mem;
  logic        ctrl_memToReg_mem;
  logic [4:0]  write_register_mem;
  logic        mem_stall;
  logic        mem_exc;
  modport master (
    output ctrl_memRead_ex_mem, ctrl_memWrite_ex_mem, mem_size_ex_mem, mem_unsigned_ex_mem,
           alu_result_ex_mem, write_data_ex_mem, ctrl_regWrite_ex_mem, ctrl_memToReg_ex_mem,
           write_register_ex_mem,
    input  read_data_from_mem, alu_result_mem, ctrl_regWrite_mem, ctrl_memToReg_mem,
           write_register_mem, mem_stall, mem_exc
  );
  modport slave (
    input  ctrl_memRead_ex_mem, ctrl_memWrite_ex_mem, mem_size_ex_mem, mem_unsigned_ex_mem,
           alu_result_ex_mem, write_data_ex_mem, ctrl_regWrite_ex_mem, ctrl_memToReg_ex_mem,
           write_register_ex_mem,
    output read_data_from_mem, alu_result_mem, ctrl_regWrite_mem, ctrl_memToReg_mem,
           write_register_mem, mem_stall, mem_exc
  );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage with data memory, sized loads/stores and wait states.
// Ports: clk, reset (async, active-high), bus (mem_access_if.slave: EX/MEM request in,
// extended load data, pass-throughs, mem_stall and mem_exc out).
module mem_access_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input logic        clk,
  input logic        reset,
  mem_access_if.slave bus
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = WAIT_STATES > 0 ? $clog2(WAIT_STATES + 1) : 1;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [31:0]   addr, wd, word, shifted, load, wdata;
  logic [IW-1:0] idx;
  logic [1:0]    sz;
  logic [3:0]    lanes;
  logic [15:0]   lh;
  logic [7:0]    lb;
  logic          rd, wr, uns, illegal, req, done, exc;
  assign rd   = bus.ctrl_memRead_ex_mem;
  assign wr   = bus.ctrl_memWrite_ex_mem;
  assign sz   = bus.mem_size_ex_mem;
  assign uns  = bus.mem_unsigned_ex_mem;
  assign addr = bus.alu_result_ex_mem;
  assign wd   = bus.write_data_ex_mem;
  assign idx  = addr[IW+1:2];
  always_comb begin
    illegal = (rd & wr) | (sz == 2'b11) | (sz == 2'b01 & addr[0]) | (sz == 2'b10 & |addr[1:0])
            | (addr[31:2] >= 30'(DEPTH_WORDS));
    req     = (rd ^ wr) & ~illegal;
    exc     = ~reset & (rd | wr) & illegal;
    // Stall covers every access cycle except the last; WAIT with cnt=0 is the completion cycle.
    done    = ~reset & req & ((WAIT_STATES == 0) | (state_q == WAIT & cnt_q == '0));
    state_d = state_q == IDLE ? ((req & (WAIT_STATES > 0)) ? WAIT : IDLE)
                              : ((req & cnt_q != '0) ? WAIT : IDLE);
    cnt_d   = state_d == WAIT ? (state_q == IDLE ? CW'(WAIT_STATES - 1) : cnt_q - 1'b1) : '0;
    word    = mem_q[idx];
    shifted = word >> {addr[1:0], 3'b000};
    lb      = shifted[7:0];
    lh      = addr[1] ? word[31:16] : word[15:0];
    load    = sz == 2'b00 ? {{24{~uns & lb[7]}}, lb}
            : sz == 2'b01 ? {{16{~uns & lh[15]}}, lh} : word;
    wdata   = sz == 2'b00 ? {4{wd[7:0]}} : sz == 2'b01 ? {2{wd[15:0]}} : wd;
    lanes   = sz == 2'b00 ? 4'b0001 << addr[1:0] : sz == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // done is gated by reset, so a store interrupted by reset never commits.
  always_ff @(posedge clk) begin
    if (done & wr)
      for (int i = 0; i < 4; i++)
        if (lanes[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
  end
  assign bus.read_data_from_mem = (done & rd) ? load : '0;
  assign bus.alu_result_mem     = addr;
  assign bus.ctrl_regWrite_mem  = bus.ctrl_regWrite_ex_mem & ~exc & ~reset;
  assign bus.ctrl_memToReg_mem  = bus.ctrl_memToReg_ex_mem;
  assign bus.write_register_mem = bus.write_register_ex_mem;
  assign bus.mem_stall          = ~reset & req & (WAIT_STATES != 0) & (state_q == IDLE | cnt_q != '0);
  assign bus.mem_exc            = exc;
endmodule
